// File: rtl/alu_serial_pkg.sv
// Shared opcodes, FSM state type and sizing helper for the slice-serial ALU.
package alu_serial_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// SLICE_W-bit combinational ALU slice with Ainvert/Binvert and ripple carry;
// also reports the carry into its MSB so the top slice can derive overflow.
module alu_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic [3:0]         alu_op,
  output logic [SLICE_W-1:0] res,
  output logic               cout,
  output logic               c_msb_in
);

  logic [SLICE_W-1:0] aa;
  logic [SLICE_W-1:0] bb;
  logic [SLICE_W:0]   sum;

  always_comb begin
    aa   = alu_op[3] ? ~a : a;
    bb   = alu_op[2] ? ~b : b;
    sum  = {1'b0, aa} + {1'b0, bb} + {{SLICE_W{1'b0}}, cin};
    cout = sum[SLICE_W];
    // sum bit = a ^ b ^ carry-in, so the MSB's carry-in falls out by XOR
    c_msb_in = aa[SLICE_W-1] ^ bb[SLICE_W-1] ^ sum[SLICE_W-1];
    case (alu_op[1:0])
      2'b00:   res = aa & bb;
      2'b01:   res = aa | bb;
      default: res = sum[SLICE_W-1:0];
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle N-bit ALU processing one SLICE_W slice per clock, LSB first.
// Optional macro ALU_SERIAL_EARLY_EXIT_EN: logic ops finish in one BUSY cycle.
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = idx_width(NSLICE);

  generate
    if (WIDTH % SLICE_W != 0) begin : g_bad_width
      $error("alu_serial: WIDTH must be a multiple of SLICE_W");
    end
  endgenerate

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic               carry_q;
  logic [IDXW-1:0]    idx_q;
  logic [SLICE_W-1:0] s_res;
  logic               s_cout, s_cmsb;
  logic               accept, last, fin, is_logic;
  logic [WIDTH-1:0]   slice_merged, busy_res, final_res;
  logic               final_c, final_v;
  int                 slice_lo;

  assign slice_lo = int'(idx_q) * SLICE_W;
  assign accept   = (state != BUSY) && start;
  assign last     = (idx_q == IDXW'(NSLICE - 1));
  assign is_logic = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_NOR);

  alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a        (a_q[slice_lo +: SLICE_W]),
    .b        (b_q[slice_lo +: SLICE_W]),
    .cin      (carry_q),
    .alu_op   (op_q),
    .res      (s_res),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  always_comb begin
    slice_merged = result;
    slice_merged[slice_lo +: SLICE_W] = s_res;
  end

`ifdef ALU_SERIAL_EARLY_EXIT_EN
  logic [WIDTH-1:0] wide_a, wide_b, wide_res;

  // Logic ops have no carry chain, so a full-width path finishes them at once
  always_comb begin
    wide_a   = op_q[3] ? ~a_q : a_q;
    wide_b   = op_q[2] ? ~b_q : b_q;
    wide_res = op_q[0] ? (wide_a | wide_b) : (wide_a & wide_b);
    fin      = last || is_logic;
    busy_res = is_logic ? wide_res : slice_merged;
  end
`else
  always_comb begin
    fin      = last;
    busy_res = slice_merged;
  end
`endif

  // SLT uses the sign of the difference corrected by overflow
  always_comb begin
    final_res = busy_res;
    final_c   = 1'b0;
    final_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        final_c = s_cout;
        final_v = s_cmsb ^ s_cout;
      end
      OP_SLT:                final_res = {{(WIDTH-1){1'b0}}, busy_res[WIDTH-1] ^ s_cmsb ^ s_cout};
      OP_AND, OP_OR, OP_NOR: final_res = busy_res;
      default:               final_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (fin)   state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BUSY);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= alu_op;
      carry_q <= alu_op[2];
      idx_q   <= '0;
    end else if (state == BUSY) begin
      idx_q   <= idx_q + 1'b1;
      carry_q <= s_cout;
      if (fin) begin
        result    <= final_res;
        zero      <= (final_res == '0);
        carry_out <= final_c;
        overflow  <= final_v;
      end else begin
        result <= slice_merged;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: directed vectors with literal expectations
// plus a per-cycle comparison against a word-level behavioural model.
module tb_alu_serial;

  localparam int W = 32;

`ifdef ALU_SERIAL_EARLY_EXIT_EN
  localparam int LOGIC_LAT = 1;
`else
  localparam int LOGIC_LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start = 1'b0;
  logic [3:0]   alu_op = 4'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, carry_out, overflow;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  alu_serial #(.WIDTH(W), .SLICE_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    e.r = '0; e.c = 1'b0; e.v = 1'b0;
    case (op)
      4'b0000: e.r = x & y;
      4'b0001: e.r = x | y;
      4'b1100: e.r = ~(x | y);
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[W-1:0]; e.c = s[W];
        e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      4'b0110: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        e.r = s[W-1:0]; e.c = s[W];
        e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      4'b0111: e.r = ($signed(x) < $signed(y)) ? 1 : 0;
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    if (op == 4'b0000 || op == 4'b0001 || op == 4'b1100) return LOGIC_LAT;
    return 4;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  // Transaction-level model: 0 idle, 1 busy, 2 done
  int   m_state = 0;
  int   m_cnt   = 0;
  exp_t m_pend;
  exp_t m_vis;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0;
      m_cnt   = 0;
      m_vis   = '{r: '0, z: 1'b0, c: 1'b0, v: 1'b0};
    end else begin
      case (m_state)
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_state = 2;
            m_vis   = m_pend;
          end
        end
        default: begin
          if (start) begin
            m_pend  = model(alu_op, a, b);
            m_cnt   = lat_of(alu_op);
            m_state = 1;
          end else begin
            m_state = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("model_busy", busy, m_state == 1);
      checkOutput("model_done", done, m_state == 2);
      if (m_state != 1) begin
        checkOutput("model_result", result, m_vis.r);
        checkOutput("model_zero", zero, m_vis.z);
        checkOutput("model_carry", carry_out, m_vis.c);
        checkOutput("model_ovf", overflow, m_vis.v);
      end
    end
  end

  // Drives one op, scrambles inputs while busy, and checks latency and outputs.
  task automatic applyStimulus(input string name, input logic [3:0] op,
                               input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] er, input logic ez, input logic ec,
                               input logic ev, input int elat);
    int n;
    @(negedge clk);
    start = 1'b1; alu_op = op; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; alu_op = 4'($urandom);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!done && n < 20);
    checkOutput({name, "_done_seen"}, done, 1'b1);
    checkOutput({name, "_latency"}, n, elat);
    checkOutput({name, "_result"}, result, er);
    checkOutput({name, "_zero"}, zero, ez);
    checkOutput({name, "_carry"}, carry_out, ec);
    checkOutput({name, "_ovf"}, overflow, ev);
  endtask

  task automatic runRandom(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    @(negedge clk);
    start = 1'b1; alu_op = op; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!done && n < 20);
    checkOutput("rand_done_seen", done, 1'b1);
  endtask

  initial begin
    int     rises[$];
    int     ndone;
    logic   prev_busy;
    logic [3:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1010};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_result", result, '0);
    checkOutput("reset_zero", zero, 1'b0);
    reset = 1'b0;

    applyStimulus("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 4);
    applyStimulus("sub_eq", 4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 4);
    applyStimulus("add_ripple", 4'b0010, 32'h000000FF, 32'h00000001, 32'h00000100, 0, 0, 0, 4);
    applyStimulus("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 4);
    applyStimulus("slt_ovf", 4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 4);
    applyStimulus("slt_ge", 4'b0111, 32'h00000003, 32'h00000002, 32'h00000000, 1, 0, 0, 4);
    applyStimulus("nor", 4'b1100, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 0, 0, 0, LOGIC_LAT);
    applyStimulus("and", 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0, 0, 0, LOGIC_LAT);
    applyStimulus("or", 4'b0001, 32'h12000034, 32'h00560000, 32'h12560034, 0, 0, 0, LOGIC_LAT);
    applyStimulus("unsup", 4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 0, 4);

    // start held high: acceptances expected at E0, E5, E10
    @(negedge clk);
    start = 1'b1; alu_op = 4'b0010;
    prev_busy = 1'b0; ndone = 0;
    for (int k = 0; k < 15; k++) begin
      a = $urandom; b = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (busy && !prev_busy) rises.push_back(k);
      if (done) ndone++;
      prev_busy = busy;
    end
    start = 1'b0;
    checkOutput("b2b_count", rises.size(), 3);
    checkOutput("b2b_done_count", ndone, 3);
    if (rises.size() == 3) begin
      checkOutput("b2b_accept1", rises[1], 5);
      checkOutput("b2b_accept2", rises[2], 10);
    end

    // a start pulse while busy must be ignored
    @(negedge clk);
    start = 1'b1; alu_op = 4'b0010; a = 32'd100; b = 32'd23;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; alu_op = 4'b0110; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("ignore_busy_start", result, 32'd123);

    // asynchronous reset after two slices, between clock edges
    @(negedge clk);
    start = 1'b1; alu_op = 4'b0010; a = 32'h11111111; b = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_busy", busy, 1'b0);
    checkOutput("areset_done", done, 1'b0);
    checkOutput("areset_result", result, '0);
    checkOutput("areset_zero", zero, 1'b0);
    checkOutput("areset_carry", carry_out, 1'b0);
    checkOutput("areset_ovf", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("add_after_reset", 4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 4);

    for (int i = 0; i < 16; i++) runRandom(ops[i % 8], $urandom, $urandom);
    runRandom(4'b0110, 32'h80000000, 32'h00000001);
    runRandom(4'b0010, 32'hFFFFFFFF, 32'h00000001);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
